// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Single-outstanding load/store unit between a CPU pipeline and a simple
// req/ack memory bus. An accepted request is checked for illegal size and
// misalignment. Faulting requests respond one cycle after acceptance without
// touching the bus. Legal requests drive one word-aligned bus access with
// little-endian byte lanes. The access completes on mem_ack or ends in a bus
// timeout after TIMEOUT cycles. Loads return the addressed bytes right-aligned
// and sign- or zero-extended.
//
// Parameters
//   DATA_W   bus/data width, 32 or 64
//   ADDR_W   byte-address width
//   TIMEOUT  BUS cycles allowed without mem_ack, 1..255
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   pipeline request handshake
//   req_we, req_size,     store flag, size code (0=B,1=H,2=W,3=D),
//   req_unsigned          zero-extend loads
//   req_addr, req_wdata   byte address, right-aligned store data
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata, rsp_exc    extended load data, exception code
//                         (00 none, 01 misaligned, 10 timeout, 11 illegal size)
//   mem_req, mem_we       bus request and direction
//   mem_addr, mem_be      aligned address, byte-lane enables
//   mem_wdata             lane-positioned store data
//   mem_ack, mem_rdata    bus completion and read data
// -----------------------------------------------------------------------------
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready for a request; req_ready=1
// BUS   | bus access in flight; mem_req=1, waiting for mem_ack
// RESP  | rsp_valid=1 for this single cycle, then back to IDLE
//
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,

    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_exc,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);

    // Counter value seen during the last permitted BUS cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    localparam logic [ADDR_W-1:0] ADDR_ALIGN = ~(ADDR_W'(BE_W - 1));

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_MISALGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT = 2'b10;
    localparam logic [1:0] EXC_ILLSIZE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic [7:0]          cnt_q;

    // Request attributes needed after acceptance.
    logic                we_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic [OFF_W-1:0]    off_q;

    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [1:0]          rsp_exc_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [BE_W-1:0]     mem_be_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    // -------------------------------------------------------------------------
    // Size helpers
    // -------------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] size_data_mask(input logic [1:0] sz);
        logic [63:0] m;
        case (sz)
            2'd0:    m = 64'h0000_0000_0000_00FF;
            2'd1:    m = 64'h0000_0000_0000_FFFF;
            2'd2:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m[DATA_W-1:0];
    endfunction

    function automatic logic [BE_W-1:0] size_lane_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m[BE_W-1:0];
    endfunction

    // -------------------------------------------------------------------------
    // Request decode (evaluated in IDLE on the incoming request)
    // -------------------------------------------------------------------------
    logic [OFF_W-1:0]  req_off;
    logic              req_illegal;
    logic              req_misalign;
    logic [BE_W-1:0]   req_be;
    logic [DATA_W-1:0] req_wdata_pos;

    assign req_off = req_addr[OFF_W-1:0];

    always_comb begin
        req_illegal = (req_size == 2'd3) && (DATA_W == 32);
        case (req_size)
            2'd0:    req_misalign = 1'b0;
            2'd1:    req_misalign = req_addr[0];
            2'd2:    req_misalign = |req_addr[1:0];
            default: req_misalign = |req_addr[2:0];
        endcase
    end

    assign req_be        = size_lane_mask(req_size) << req_off;
    assign req_wdata_pos = (req_wdata & size_data_mask(req_size)) << {req_off, 3'b000};

    // -------------------------------------------------------------------------
    // Load extraction from the bus word using the latched attributes
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] ld_shifted;
    logic [DATA_W-1:0] ld_mask;
    logic [DATA_W-1:0] ld_result;
    logic              ld_sign;

    always_comb begin
        ld_shifted = mem_rdata >> {off_q, 3'b000};
        ld_mask    = size_data_mask(size_q);
        case (size_q)
            2'd0:    ld_sign = ld_shifted[7];
            2'd1:    ld_sign = ld_shifted[15];
            2'd2:    ld_sign = ld_shifted[31];
            default: ld_sign = ld_shifted[DATA_W-1];
        endcase
        ld_result = ld_shifted & ld_mask;
        // For a full-width access ~ld_mask is zero, so the word passes unchanged.
        if (!uns_q && ld_sign) begin
            ld_result = ld_result | ~ld_mask;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            off_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_exc_q   <= EXC_NONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q   <= req_we;
                        size_q <= req_size;
                        uns_q  <= req_unsigned;
                        off_q  <= req_off;

                        if (req_illegal || req_misalign) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_exc_q   <= req_illegal ? EXC_ILLSIZE : EXC_MISALGN;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q     <= S_BUS;
                            cnt_q       <= 8'd0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_we;
                            mem_addr_q  <= req_addr & ADDR_ALIGN;
                            mem_be_q    <= req_be;
                            mem_wdata_q <= req_we ? req_wdata_pos : '0;
                        end
                    end
                end

                S_BUS: begin
                    if (mem_ack) begin
                        // An ack on the expiry cycle still completes normally.
                        state_q     <= S_RESP;
                        mem_req_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_exc_q   <= EXC_NONE;
                        rsp_rdata_q <= we_q ? '0 : ld_result;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == CNT_LAST) begin
                            state_q     <= S_RESP;
                            mem_req_q   <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_exc_q   <= EXC_TIMEOUT;
                            rsp_rdata_q <= '0;
                        end
                    end
                end

                S_RESP: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_exc   = rsp_exc_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed bench for mem_access_unit. Two instances are used. The first is
// 32-bit with TIMEOUT=3. The second is 64-bit with the default TIMEOUT.
// Inputs are shared between the two; sel64 gates req_valid and mem_ack to one
// instance and selects which instance's outputs are observed.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        sel64;

    int tests_run    = 0;
    int tests_failed = 0;

    // 32-bit instance outputs
    logic        rdy32, rv32, mreq32, mwe32;
    logic [31:0] rdata32, maddr32, mwdata32;
    logic [1:0]  exc32;
    logic [3:0]  be32;

    // 64-bit instance outputs
    logic        rdy64, rv64, mreq64, mwe64;
    logic [63:0] rdata64, mwdata64;
    logic [31:0] maddr64;
    logic [1:0]  exc64;
    logic [7:0]  be64;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(3)) u_dut32 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid & ~sel64),
        .req_ready    (rdy32),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata[31:0]),
        .rsp_valid    (rv32),
        .rsp_rdata    (rdata32),
        .rsp_exc      (exc32),
        .mem_req      (mreq32),
        .mem_we       (mwe32),
        .mem_addr     (maddr32),
        .mem_be       (be32),
        .mem_wdata    (mwdata32),
        .mem_ack      (mem_ack & ~sel64),
        .mem_rdata    (mem_rdata[31:0])
    );

    mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(15)) u_dut64 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid & sel64),
        .req_ready    (rdy64),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rv64),
        .rsp_rdata    (rdata64),
        .rsp_exc      (exc64),
        .mem_req      (mreq64),
        .mem_we       (mwe64),
        .mem_addr     (maddr64),
        .mem_be       (be64),
        .mem_wdata    (mwdata64),
        .mem_ack      (mem_ack & sel64),
        .mem_rdata    (mem_rdata)
    );

    // Observed outputs of the selected instance, widened to 64 bits.
    logic [63:0] o_ready, o_valid, o_rdata, o_exc, o_req, o_we, o_addr, o_be, o_wdata;
    assign o_ready = {63'b0, sel64 ? rdy64  : rdy32};
    assign o_valid = {63'b0, sel64 ? rv64   : rv32};
    assign o_req   = {63'b0, sel64 ? mreq64 : mreq32};
    assign o_we    = {63'b0, sel64 ? mwe64  : mwe32};
    assign o_exc   = {62'b0, sel64 ? exc64  : exc32};
    assign o_rdata = sel64 ? rdata64  : {32'b0, rdata32};
    assign o_wdata = sel64 ? mwdata64 : {32'b0, mwdata32};
    assign o_addr  = {32'b0, sel64 ? maddr64 : maddr32};
    assign o_be    = sel64 ? {56'b0, be64} : {60'b0, be32};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents a request in the current IDLE cycle; returns 1 time unit
    // after the acceptance edge N, i.e. at the start of cycle N+1.
    task automatic issue(input logic sel, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [63:0] wd);
        @(negedge clk);
        sel64 = sel;
        #1;
        check("ready_in_idle", o_ready, 64'd1);
        check("no_rsp_in_idle", o_valid, 64'd0);
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Called at a negedge inside BUS: ack is sampled at the coming edge.
    task automatic ack_now(input logic [63:0] rd);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
    endtask

    typedef struct {
        logic        sel;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [63:0] rd;
        logic [63:0] be;
        logic [63:0] maddr;
        logic [63:0] res;
    } load_vec_t;

    load_vec_t lv[13];

    task automatic do_store(input logic sel, input logic [1:0] sz, input logic [31:0] addr,
                            input logic [63:0] wd, input logic [63:0] exp_be,
                            input logic [63:0] exp_wd, input logic [63:0] exp_addr);
        issue(sel, 1'b1, sz, 1'b0, addr, wd);
        @(negedge clk);
        check("st_req", o_req, 64'd1);
        check("st_we", o_we, 64'd1);
        check("st_be", o_be, exp_be);
        check("st_wdata", o_wdata, exp_wd);
        check("st_addr", o_addr, exp_addr);
        ack_now(64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        check("st_rsp_valid", o_valid, 64'd1);
        check("st_rsp_rdata", o_rdata, 64'd0);
        check("st_rsp_exc", o_exc, 64'd0);
    endtask

    task automatic do_exc(input logic sel, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [63:0] exp_exc);
        issue(sel, 1'b0, sz, 1'b0, addr, 64'd0);
        @(negedge clk);
        check("exc_rsp_valid", o_valid, 64'd1);
        check("exc_code", o_exc, exp_exc);
        check("exc_rdata", o_rdata, 64'd0);
        check("exc_no_mem_req", o_req, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 64'd0;
        mem_ack = 1'b0; mem_rdata = 64'd0; sel64 = 1'b0;

        lv[0]  = '{1'b0, 2'd0, 1'b0, 32'h1003, 64'h80AA55CC, 64'h8, 64'h1000, 64'hFFFFFF80};
        lv[1]  = '{1'b0, 2'd0, 1'b1, 32'h1003, 64'h80AA55CC, 64'h8, 64'h1000, 64'h00000080};
        lv[2]  = '{1'b0, 2'd0, 1'b0, 32'h1001, 64'h80AA55CC, 64'h2, 64'h1000, 64'h00000055};
        lv[3]  = '{1'b0, 2'd0, 1'b0, 32'h1000, 64'h80AA55CC, 64'h1, 64'h1000, 64'hFFFFFFCC};
        lv[4]  = '{1'b0, 2'd1, 1'b1, 32'h1002, 64'h80AA55CC, 64'hC, 64'h1000, 64'h000080AA};
        lv[5]  = '{1'b0, 2'd1, 1'b0, 32'h1002, 64'h80AA55CC, 64'hC, 64'h1000, 64'hFFFF80AA};
        lv[6]  = '{1'b0, 2'd1, 1'b0, 32'h1000, 64'h80AA55CC, 64'h3, 64'h1000, 64'h000055CC};
        lv[7]  = '{1'b0, 2'd2, 1'b0, 32'h1004, 64'h80AA55CC, 64'hF, 64'h1004, 64'h80AA55CC};
        lv[8]  = '{1'b1, 2'd2, 1'b1, 32'h0104, 64'h89ABCDEF_01234567, 64'hF0, 64'h0100, 64'h00000000_89ABCDEF};
        lv[9]  = '{1'b1, 2'd2, 1'b0, 32'h0104, 64'h89ABCDEF_01234567, 64'hF0, 64'h0100, 64'hFFFFFFFF_89ABCDEF};
        lv[10] = '{1'b1, 2'd3, 1'b0, 32'h0108, 64'h89ABCDEF_01234567, 64'hFF, 64'h0108, 64'h89ABCDEF_01234567};
        lv[11] = '{1'b1, 2'd1, 1'b0, 32'h0102, 64'h89ABCDEF_01234567, 64'h0C, 64'h0100, 64'h00000000_00000123};
        lv[12] = '{1'b1, 2'd0, 1'b0, 32'h0107, 64'h89ABCDEF_01234567, 64'h80, 64'h0100, 64'hFFFFFFFF_FFFFFF89};

        // Reset values, checked before any clock edge.
        #1;
        check("rst_ready", o_ready, 64'd1);
        check("rst_valid", o_valid, 64'd0);
        check("rst_rdata", o_rdata, 64'd0);
        check("rst_exc", o_exc, 64'd0);
        check("rst_req", o_req, 64'd0);
        check("rst_we", o_we, 64'd0);
        check("rst_addr", o_addr, 64'd0);
        check("rst_be", o_be, 64'd0);
        check("rst_wdata", o_wdata, 64'd0);
        sel64 = 1'b1;
        #1;
        check("rst64_ready", o_ready, 64'd1);
        check("rst64_req", o_req, 64'd0);
        sel64 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Stray ack while idle must be ignored.
        @(negedge clk);
        ack_now(64'h1234_5678);
        @(negedge clk);
        check("idle_ack_ignored", o_valid, 64'd0);

        // Loads, ack in the first BUS cycle; response in cycle N+2, then the
        // next request is presented in the IDLE cycle right after RESP.
        foreach (lv[i]) begin
            issue(lv[i].sel, 1'b0, lv[i].sz, lv[i].uns, lv[i].addr, 64'hA5A5_A5A5_A5A5_A5A5);
            @(negedge clk);
            check("ld_req", o_req, 64'd1);
            check("ld_busy", o_ready, 64'd0);
            check("ld_we", o_we, 64'd0);
            check("ld_be", o_be, lv[i].be);
            check("ld_addr", o_addr, lv[i].maddr);
            check("ld_wdata", o_wdata, 64'd0);
            check("ld_no_early_rsp", o_valid, 64'd0);
            ack_now(lv[i].rd);
            @(negedge clk);
            check("ld_rsp_valid", o_valid, 64'd1);
            check("ld_rdata", o_rdata, lv[i].res);
            check("ld_exc", o_exc, 64'd0);
            check("ld_req_dropped", o_req, 64'd0);
        end
        @(negedge clk);
        check("rsp_pulse_once", o_valid, 64'd0);
        check("rsp_rdata_hold", o_rdata, 64'hFFFFFFFF_FFFFFF89);

        // Store half with a stray request during BUS and ack in BUS cycle 2.
        issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h2002, 64'h1234BEEF);
        @(negedge clk);
        check("sth_req", o_req, 64'd1);
        check("sth_we", o_we, 64'd1);
        check("sth_be", o_be, 64'hC);
        check("sth_addr", o_addr, 64'h2000);
        check("sth_wdata", o_wdata, 64'hBEEF0000);
        req_valid = 1'b1; req_addr = 32'h4001; req_we = 1'b0; req_size = 2'd0;
        @(negedge clk);
        req_valid = 1'b0;
        check("sth_hold_req", o_req, 64'd1);
        check("sth_hold_addr", o_addr, 64'h2000);
        check("sth_hold_be", o_be, 64'hC);
        check("sth_hold_wdata", o_wdata, 64'hBEEF0000);
        check("sth_hold_we", o_we, 64'd1);
        check("sth_no_rsp_c2", o_valid, 64'd0);
        ack_now(64'hDEADBEEF);
        @(negedge clk);
        check("sth_rsp_valid", o_valid, 64'd1);
        check("sth_rdata", o_rdata, 64'd0);
        check("sth_exc", o_exc, 64'd0);

        do_store(1'b0, 2'd0, 32'h2001, 64'hFFFFFF5A, 64'h2, 64'h00005A00, 64'h2000);
        do_store(1'b1, 2'd0, 32'h0107, 64'h000000AB, 64'h80, 64'hAB000000_00000000, 64'h0100);
        do_store(1'b1, 2'd3, 32'h0110, 64'h01234567_89ABCDEF, 64'hFF, 64'h01234567_89ABCDEF, 64'h0110);

        // Exceptions: response in cycle N+1, no bus access.
        do_exc(1'b0, 2'd2, 32'h0006, 64'd1);
        do_exc(1'b0, 2'd1, 32'h1001, 64'd1);
        do_exc(1'b0, 2'd3, 32'h1000, 64'd3);
        do_exc(1'b0, 2'd3, 32'h1001, 64'd3);
        do_exc(1'b1, 2'd3, 32'h0104, 64'd1);
        do_exc(1'b1, 2'd2, 32'h0102, 64'd1);

        // TIMEOUT=3: ack in the 3rd BUS cycle completes normally.
        issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h3000, 64'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("to_ack_req", o_req, 64'd1);
            check("to_ack_no_rsp", o_valid, 64'd0);
        end
        ack_now(64'h11223344);
        @(negedge clk);
        check("to_ack_rsp_valid", o_valid, 64'd1);
        check("to_ack_exc", o_exc, 64'd0);
        check("to_ack_rdata", o_rdata, 64'h11223344);

        // TIMEOUT=3 without ack: mem_req for 3 cycles, timeout at N+4.
        issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h3000, 64'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("to_req", o_req, 64'd1);
            check("to_no_rsp", o_valid, 64'd0);
        end
        @(negedge clk);
        check("to_rsp_valid", o_valid, 64'd1);
        check("to_exc", o_exc, 64'd2);
        check("to_rdata", o_rdata, 64'd0);
        check("to_req_dropped", o_req, 64'd0);

        // Reset mid-BUS aborts the access; a later ack is ignored.
        issue(1'b0, 1'b0, 2'd0, 1'b0, 32'h5001, 64'd0);
        @(negedge clk);
        check("ab_req", o_req, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ab_req_low", o_req, 64'd0);
        check("ab_ready", o_ready, 64'd1);
        check("ab_valid", o_valid, 64'd0);
        check("ab_exc", o_exc, 64'd0);
        check("ab_be", o_be, 64'd0);
        check("ab_addr", o_addr, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ack_now(64'hCAFEF00D);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("ab_no_rsp", o_valid, 64'd0);
            check("ab_idle_ready", o_ready, 64'd1);
            check("ab_idle_req", o_req, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
  DATA_W, 32, bus/data width in bits; legal values 32 or 64.
  ADDR_W, 32, byte-address width.
  TIMEOUT, 15, maximum BUS-state cycles without mem_ack; legal range 1..255.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
  clk  in  1  sole clock; all state updates on the rising edge.
  rst_n  in  1  asynchronous reset, active-low.
  req_valid  in  1  pipeline access request.
  req_ready  out  1  unit can accept a request.
  req_we  in  1  1 = store, 0 = load.
  req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword.
  req_unsigned  in  1  zero-extend loads when 1; sign-extend when 0.
  req_addr  in  ADDR_W  byte address.
  req_wdata  in  DATA_W  store value, right-aligned.
  rsp_valid  out  1  one-cycle completion pulse.
  rsp_rdata  out  DATA_W  extended load result.
  rsp_exc  out  2  exception code: 00 = none, 01 = misaligned, 10 = bus timeout, 11 = illegal size.
  mem_req  out  1  bus request.
  mem_we  out  1  bus write.
  mem_addr  out  ADDR_W  req_addr with its low log2(DATA_W/8) bits cleared.
  mem_be  out  DATA_W/8  byte-lane enables.
  mem_wdata  out  DATA_W  lane-positioned store data.
  mem_ack  in  1  bus completion.
  mem_rdata  in  DATA_W  bus read data; valid with mem_ack.

Function
REQ-003 FSM states SHALL be IDLE, BUS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-004 Acceptance SHALL occur on a rising edge with req_valid=1 and req_ready=1; all req_* fields are latched at that edge.
REQ-005 Illegal size SHALL be detected when req_size=3 and DATA_W=32.
REQ-006 Misalignment SHALL be detected when req_addr mod 2^req_size != 0; illegal size takes priority over misalignment.
REQ-007 On an exception at acceptance, the FSM SHALL go IDLE->RESP with no bus access (mem_req stays 0), rsp_exc set to the code and rsp_rdata=0.
REQ-008 Otherwise the FSM SHALL go IDLE->BUS; mem_req=1 and mem_we/addr/be/wdata SHALL hold constant for the whole of BUS.
REQ-009 Byte lanes SHALL be little-endian: offset = req_addr[log2(DATA_W/8)-1:0]; mem_be = (2^(2^size)-1) << offset for both loads and stores.
REQ-010 mem_wdata SHALL be the low 2^size bytes of req_wdata shifted left by offset*8, with unused lanes 0; for loads mem_wdata=0.
REQ-011 In BUS, when mem_ack=1 the unit SHALL capture mem_rdata and go to RESP; mem_req SHALL be 0 from the next cycle.
REQ-012 Load result SHALL be the 2^size bytes at offset, right-aligned, then sign- or zero-extended to DATA_W per req_unsigned; a full-width access returns the data unchanged.
REQ-013 For stores, rsp_rdata SHALL be 0.
REQ-014 A cycle counter SHALL clear on entry to BUS and increment each BUS cycle without mem_ack.
REQ-015 When TIMEOUT cycles elapse without mem_ack, the unit SHALL drop mem_req, go to RESP with rsp_exc=10 and rsp_rdata=0; a mem_ack in the same cycle as expiry wins (normal completion).
REQ-016 In RESP, rsp_valid=1 for exactly one cycle, then the FSM SHALL return to IDLE; rsp_rdata and rsp_exc SHALL hold until the next RESP.
REQ-017 Latency SHALL be: accept at edge N -> rsp_valid in cycle N+1 on exception, N+2 at minimum on a bus access (ack in the first BUS cycle), and N+1+k when ack arrives in the k-th BUS cycle.
REQ-018 mem_ack outside BUS SHALL be ignored; req_valid outside IDLE SHALL be ignored and the request is not latched.
REQ-019 Back-to-back operation SHALL allow a new acceptance in the IDLE cycle that follows RESP; at most one access is outstanding.

Reset
REQ-020 While rst_n=0, asynchronously and regardless of clk, the unit SHALL be: state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_exc=00; mem_req=0; mem_we=0; mem_addr=0; mem_be=0; mem_wdata=0; counter=0.
REQ-021 Reset asserted mid-access SHALL abort it: mem_req falls immediately, no response is produced, and a later mem_ack is ignored.

Verification
REQ-022 DATA_W=32, load byte, addr 0x1003, signed, mem_rdata=0x80AA55CC, ack in the first BUS cycle -> mem_be=1000, mem_addr=0x1000, rsp_rdata=0xFFFFFF80 at N+2, rsp_exc=00.
REQ-023 DATA_W=32, store half, addr 0x2002, wdata=0x1234BEEF -> mem_be=1100, mem_wdata=0xBEEF0000, mem_we=1, rsp_rdata=0.
REQ-024 Load word at addr 0x0006 -> rsp_exc=01 at N+1, mem_req never asserted.
REQ-025 TIMEOUT=3, no ack -> mem_req high for exactly 3 cycles, rsp_exc=10 at N+4; an ack in the 3rd cycle instead gives a normal completion.
REQ-026 DATA_W=64, load unsigned word, addr 0x...04, mem_rdata=0x89ABCDEF_01234567 -> rsp_rdata=0x00000000_89ABCDEF; req_size=3 with DATA_W=32 -> rsp_exc=11.
REQ-027 rst_n pulsed low mid-BUS, with an ack arriving afterwards -> mem_req=0 immediately, no rsp_valid, req_ready=1.
